// File: rtl/lcd1602_ctrl.sv
// lcd1602_ctrl: FIFO-buffered HD44780 write sequencer with autonomous setup/enable/hold/exec timing
module lcd1602_ctrl #(
    parameter int FIFO_DEPTH    = 4,
    parameter int SETUP_CYC     = 2,
    parameter int E_HIGH_CYC    = 12,
    parameter int HOLD_CYC      = 2,
    parameter int EXEC_CYC      = 1024,
    parameter int SLOW_EXEC_CYC = 41000
) (
    input  logic       in_clock,
    input  logic       rst,
    input  logic       wr_stb,
    input  logic       wr_rs,
    input  logic [7:0] wr_data,
    input  logic       ovf_clr,
    output logic [7:0] status,
    output logic       busy,
    output logic       full,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [7:0] lcd_data
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int M1 = SETUP_CYC > E_HIGH_CYC ? SETUP_CYC : E_HIGH_CYC;
    localparam int M2 = HOLD_CYC > EXEC_CYC ? HOLD_CYC : EXEC_CYC;
    localparam int M3 = M1 > M2 ? M1 : M2;
    localparam int MAXC = M3 > SLOW_EXEC_CYC ? M3 : SLOW_EXEC_CYC;
    localparam int CW = MAXC > 1 ? $clog2(MAXC) : 1;

    typedef enum logic [2:0] {IDLE, SETUP, EHIGH, HOLD, EXEC} state_t;

    state_t        state;
    logic [8:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wp, rp;
    logic [LW-1:0] cnt, cnt_nx;
    logic [CW-1:0] ctr;
    logic          ovf, push, pop, slow;

    assign push   = wr_stb && !full;
    assign pop    = state == IDLE && cnt != '0;
    assign cnt_nx = cnt + LW'(push) - LW'(pop);
    // Clear (0x01) and Return Home (0x02/0x03) need the long execution delay
    assign slow   = !lcd_rs && lcd_data[7:2] == 6'd0 && lcd_data[1:0] != 2'd0;
    assign lcd_rw = 1'b0;
    assign status = {busy, full, ovf, 1'b0, 4'(cnt)};

    always_ff @(posedge in_clock) begin
        if (push) mem[wp] <= {wr_rs, wr_data};
        if (rst) begin
            wp   <= '0;
            rp   <= '0;
            cnt  <= '0;
            full <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            wp   <= wp + AW'(push);
            rp   <= rp + AW'(pop);
            cnt  <= cnt_nx;
            full <= cnt_nx == LW'(FIFO_DEPTH);
            ovf  <= (wr_stb && full) || (ovf && !ovf_clr);
        end
    end

    always_ff @(posedge in_clock) begin
        if (rst) begin
            state    <= IDLE;
            ctr      <= '0;
            busy     <= 1'b0;
            lcd_e    <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_data <= 8'h00;
        end else begin
            busy <= cnt != '0 || state != IDLE;
            if (state != IDLE && ctr != '0) begin
                ctr <= ctr - CW'(1);
            end else begin
                case (state)
                    IDLE: if (pop) begin
                        {lcd_rs, lcd_data} <= mem[rp];
                        ctr   <= CW'(SETUP_CYC - 1);
                        state <= SETUP;
                    end
                    SETUP: begin
                        lcd_e <= 1'b1;
                        ctr   <= CW'(E_HIGH_CYC - 1);
                        state <= EHIGH;
                    end
                    EHIGH: begin
                        lcd_e <= 1'b0;
                        ctr   <= CW'(HOLD_CYC - 1);
                        state <= HOLD;
                    end
                    HOLD: begin
                        ctr   <= slow ? CW'(SLOW_EXEC_CYC - 1) : CW'(EXEC_CYC - 1);
                        state <= EXEC;
                    end
                    EXEC:    state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
